// File: rtl/lc3b_mdu.sv
// Iterative unsigned multiply/divide unit for the LC-3b EX stage (shift-add multiply, restoring divide).
// Optional build macro LC3B_MDU_EARLY_OUT_EN: multiplies finish as soon as no multiplier bits remain.
module lc3b_mdu #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] f,
    output logic             div0
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    localparam logic [1:0] OP_MUL   = 2'b00;
    localparam logic [1:0] OP_MULHU = 2'b01;
    localparam logic [1:0] OP_DIVU  = 2'b10;

    state_t             state_reg, state_next;
    logic [1:0]         op_reg, op_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [2*WIDTH-1:0] acc_reg, acc_next;
    logic [2*WIDTH-1:0] mcand_reg, mcand_next;
    logic [WIDTH-1:0]   mplier_reg, mplier_next;
    logic [WIDTH:0]     rem_reg, rem_next;
    logic [WIDTH-1:0]   quo_reg, quo_next;
    logic [WIDTH-1:0]   dvsr_reg, dvsr_next;
    logic [WIDTH-1:0]   f_reg, f_next;
    logic               div0_reg, div0_next;

    logic [2*WIDTH-1:0] prod_sum;
    logic [WIDTH:0]     trial;
    logic               q_bit;
    logic [WIDTH:0]     rem_step;
    logic [WIDTH-1:0]   quo_step;
    logic               is_div;
    logic               finish;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            op_reg     <= '0;
            cnt_reg    <= '0;
            acc_reg    <= '0;
            mcand_reg  <= '0;
            mplier_reg <= '0;
            rem_reg    <= '0;
            quo_reg    <= '0;
            dvsr_reg   <= '0;
            f_reg      <= '0;
            div0_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            op_reg     <= op_next;
            cnt_reg    <= cnt_next;
            acc_reg    <= acc_next;
            mcand_reg  <= mcand_next;
            mplier_reg <= mplier_next;
            rem_reg    <= rem_next;
            quo_reg    <= quo_next;
            dvsr_reg   <= dvsr_next;
            f_reg      <= f_next;
            div0_reg   <= div0_next;
        end
    end

    // One step of each algorithm, evaluated every cycle; only CALC commits it.
    always_comb begin
        prod_sum = acc_reg + (mplier_reg[0] ? mcand_reg : '0);
        trial    = (rem_reg << 1) | (WIDTH+1)'(quo_reg[WIDTH-1]);
        q_bit    = (trial >= {1'b0, dvsr_reg});
        rem_step = q_bit ? (trial - {1'b0, dvsr_reg}) : trial;
        quo_step = {quo_reg[WIDTH-2:0], q_bit};
        is_div   = op_reg[1];
`ifdef LC3B_MDU_EARLY_OUT_EN
        finish   = (cnt_reg == CNT_W'(WIDTH-1)) ||
                   (!is_div && ((mplier_reg >> 1) == '0));
`else
        finish   = (cnt_reg == CNT_W'(WIDTH-1));
`endif
    end

    always_comb begin
        state_next  = state_reg;
        op_next     = op_reg;
        cnt_next    = cnt_reg;
        acc_next    = acc_reg;
        mcand_next  = mcand_reg;
        mplier_next = mplier_reg;
        rem_next    = rem_reg;
        quo_next    = quo_reg;
        dvsr_next   = dvsr_reg;
        f_next      = f_reg;
        div0_next   = div0_reg;
        ready       = 1'b0;
        done        = 1'b0;

        case (state_reg)
            IDLE: begin
                ready = 1'b1;
                if (start) begin
                    op_next     = op;
                    cnt_next    = '0;
                    acc_next    = '0;
                    mcand_next  = {{WIDTH{1'b0}}, a};
                    mplier_next = b;
                    rem_next    = '0;
                    quo_next    = a;
                    dvsr_next   = b;
                    state_next  = CALC;
                end
            end
            CALC: begin
                cnt_next    = cnt_reg + 1'b1;
                acc_next    = prod_sum;
                mcand_next  = mcand_reg << 1;
                mplier_next = mplier_reg >> 1;
                rem_next    = rem_step;
                quo_next    = quo_step;
                if (finish) begin
                    case (op_reg)
                        OP_MUL:   f_next = prod_sum[WIDTH-1:0];
                        OP_MULHU: f_next = prod_sum[2*WIDTH-1:WIDTH];
                        OP_DIVU:  f_next = quo_step;
                        default:  f_next = rem_step[WIDTH-1:0];
                    endcase
                    div0_next  = is_div && (dvsr_reg == '0);
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign f    = f_reg;
    assign div0 = div0_reg;

endmodule

// File: tb/tb_lc3b_mdu.sv
// Self-checking bench for lc3b_mdu: directed cases plus randomized operations against an arithmetic model.
module tb_lc3b_mdu;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic        ready;
    logic        done;
    logic [15:0] f;
    logic        div0;

    int n_checks = 0;
    int n_fail   = 0;

    lc3b_mdu dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .ready (ready),
        .done  (done),
        .f     (f),
        .div0  (div0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Result model from plain arithmetic; returns {div0, f}.
    function automatic logic [16:0] ref_result(input logic [1:0] o, input logic [15:0] x, input logic [15:0] y);
        logic [31:0] p;
        p = {16'h0, x} * {16'h0, y};
        case (o)
            2'b00:   return {1'b0, p[15:0]};
            2'b01:   return {1'b0, p[31:16]};
            2'b10:   return (y == 0) ? {1'b1, 16'hFFFF} : {1'b0, x / y};
            default: return (y == 0) ? {1'b1, x} : {1'b0, x % y};
        endcase
    endfunction

    // Cycles from the accept edge to the cycle in which done is high.
    function automatic int ref_latency(input logic [1:0] o, input logic [15:0] y);
        int n;
        n = 16;
`ifdef LC3B_MDU_EARLY_OUT_EN
        if (o[1] == 1'b0) begin
            n = 1;
            for (int i = 0; i < 16; i++)
                if (y[i]) n = i + 1;
        end
`endif
        return n;
    endfunction

    // Issue one operation and check result, latency and single done pulse.
    task automatic do_op(input string tag, input logic [1:0] o, input logic [15:0] x, input logic [15:0] y,
                         input logic [15:0] exp_f, input logic exp_d0, input int exp_lat, input bit inj);
        int cycles;
        int w;
        w = 0;
        while (!ready && w < 40) begin
            @(posedge clk); #1;
            w++;
        end
        chk({tag, "_ready_before"}, 32'(ready), 32'd1);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk); #1;
        start = 1'b0; a = 16'($urandom); b = 16'($urandom); op = 2'($urandom);
        cycles = 0;
        while (cycles < 40) begin
            @(posedge clk); #1;
            cycles++;
            if (done) break;
            if (inj && (cycles == 2 || cycles == 9)) begin
                start = 1'b1; a = 16'($urandom); b = 16'($urandom); op = 2'($urandom);
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        chk({tag, "_done_seen"}, 32'(done), 32'd1);
        chk({tag, "_latency"}, 32'(cycles), 32'(exp_lat));
        chk({tag, "_f"}, 32'(f), 32'(exp_f));
        chk({tag, "_div0"}, 32'(div0), 32'(exp_d0));
        chk({tag, "_ready_in_done"}, 32'(ready), 32'd0);
        @(posedge clk); #1;
        chk({tag, "_done_single"}, 32'(done), 32'd0);
        chk({tag, "_ready_after"}, 32'(ready), 32'd1);
        chk({tag, "_f_hold"}, 32'(f), 32'(exp_f));
        $display("op=%0d a=%h b=%h -> f=%h div0=%0d latency=%0d", o, x, y, f, div0, cycles);
    endtask

    initial begin
        logic [1:0]  ro;
        logic [15:0] ra;
        logic [15:0] rb;
        logic [16:0] exp;
        int          seen;

        rst = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("reset_ready", 32'(ready), 32'd1);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_f", 32'(f), 32'h0);
        chk("reset_div0", 32'(div0), 32'd0);

        do_op("mul", 2'b00, 16'h1234, 16'h0010, 16'h2340, 1'b0, ref_latency(2'b00, 16'h0010), 1'b0);
        do_op("mulhu", 2'b01, 16'h1234, 16'h0010, 16'h0001, 1'b0, ref_latency(2'b01, 16'h0010), 1'b0);
        do_op("divu", 2'b10, 16'h0064, 16'h0007, 16'h000E, 1'b0, 16, 1'b0);
        do_op("remu", 2'b11, 16'h0064, 16'h0007, 16'h0002, 1'b0, 16, 1'b0);
        do_op("divu_max", 2'b10, 16'hFFFF, 16'h0001, 16'hFFFF, 1'b0, 16, 1'b0);
        do_op("divu_zero", 2'b10, 16'h00AB, 16'h0000, 16'hFFFF, 1'b1, 16, 1'b0);
        do_op("remu_zero", 2'b11, 16'h00AB, 16'h0000, 16'h00AB, 1'b1, 16, 1'b0);
        do_op("mul_inject", 2'b00, 16'hBEEF, 16'h8001, 16'h3EEF, 1'b0, 16, 1'b1);
        do_op("mul_ff_x3", 2'b00, 16'h00FF, 16'h0003, 16'h02FD, 1'b0, ref_latency(2'b00, 16'h0003), 1'b0);
        do_op("mulhu_full", 2'b01, 16'hFFFF, 16'hFFFF, 16'hFFFE, 1'b0, 16, 1'b0);

        // Leave a nonzero result in f so the reset clearing it is visible.
        do_op("remu_pre_rst", 2'b11, 16'h00AB, 16'h0000, 16'h00AB, 1'b1, 16, 1'b0);
        start = 1'b1; op = 2'b10; a = 16'h1234; b = 16'h0003;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_ready", 32'(ready), 32'd1);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_f", 32'(f), 32'h0);
        chk("midrst_div0", 32'(div0), 32'd0);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (done) seen++;
        end
        chk("midrst_no_done", 32'(seen), 32'd0);
        $display("mid-operation reset: ready=%0d f=%h done_pulses=%0d", ready, f, seen);

        for (int i = 0; i < 40; i++) begin
            ro = 2'($urandom);
            ra = 16'($urandom);
            case ($urandom_range(0, 3))
                0:       rb = 16'h0000;
                1:       rb = 16'($urandom_range(1, 15));
                default: rb = 16'($urandom);
            endcase
            exp = ref_result(ro, ra, rb);
            do_op("rand", ro, ra, rb, exp[15:0], exp[16], ref_latency(ro, rb), bit'(i % 5 == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
